// File: rtl/muldiv_pkg.sv
// Shared types and opcode decode helpers for the iterative M-extension unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } muldiv_state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return (op == OpDiv) || (op == OpDivu) || (op == OpRem) || (op == OpRemu);
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return (op == OpRem) || (op == OpRemu);
    endfunction

    // Low half of MUL is sign-agnostic, so it is handled as unsigned.
    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic returns_high(input muldiv_op_e op);
        return (op == OpMulh) || (op == OpMulhsu) || (op == OpMulhu);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fix.
module muldiv_negate #(
    parameter int unsigned Width = 32
) (
    input  logic             neg_i,
    input  logic [Width-1:0] a_i,
    output logic [Width-1:0] y_o
);

    assign y_o = neg_i ? -a_i : a_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply, restoring divide,
// one bit per cycle, with the RISC-V divide-by-zero / overflow results short-circuited.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [2:0]                op_i,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_i,
    input  logic                      flush_i,
    output logic                      valid_o,
    output logic [DATA_WIDTH-1:0]     result_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_o,
    output logic                      busy_o
);

    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);
    localparam logic [W-1:0]    MinNeg  = {1'b1, {(W - 1){1'b0}}};

    muldiv_state_e             state_q, state_d;
    muldiv_op_e                op_q, op_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d, rd_out_q, rd_out_d;
    logic [2*W-1:0]            acc_q, acc_d;
    logic [W-1:0]              opnd_q, opnd_d;
    logic                      neg_q, neg_d;
    logic                      rem_neg_q, rem_neg_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [W-1:0]              result_q, result_d;

    muldiv_op_e   op_in;
    logic         a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    logic         special_zero, special_ovf;
    logic [W-1:0] special_res;

    assign op_in = muldiv_op_e'(op_i);
    assign a_neg = a_i[W-1] & is_signed_a(op_in);
    assign b_neg = b_i[W-1] & is_signed_b(op_in);

    muldiv_negate #(.Width(W)) u_abs_a (.neg_i(a_neg), .a_i(a_i), .y_o(a_mag));
    muldiv_negate #(.Width(W)) u_abs_b (.neg_i(b_neg), .a_i(b_i), .y_o(b_mag));

    assign special_zero = is_div(op_in) && (b_i == '0);
    assign special_ovf  = ((op_in == OpDiv) || (op_in == OpRem)) && (a_i == MinNeg) && (&b_i);

    always_comb begin
        if (special_zero) begin
            special_res = is_rem(op_in) ? a_i : '1;
        end else begin
            special_res = is_rem(op_in) ? '0 : a_i;
        end
    end

    // Multiply step: low half of acc holds the remaining multiplier bits.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Divide step: acc = {partial remainder, dividend bits shifting into quotient}.
    logic [W:0]     div_rem_sh;
    logic           div_ge;
    logic [W-1:0]   div_rem_new;
    logic [2*W-1:0] div_next;
    assign div_rem_sh  = acc_q[2*W-1:W-1];
    assign div_ge      = div_rem_sh >= {1'b0, opnd_q};
    assign div_rem_new = div_ge ? W'(div_rem_sh - {1'b0, opnd_q}) : div_rem_sh[W-1:0];
    assign div_next    = {div_rem_new, acc_q[W-2:0], div_ge};

    logic [2*W-1:0] prod_fixed;
    logic [W-1:0]   mul_result;
    logic [W-1:0]   div_raw, div_fixed;
    logic           div_sign;

    muldiv_negate #(.Width(2 * W)) u_fix_prod (
        .neg_i(neg_q),
        .a_i  (mul_next),
        .y_o  (prod_fixed)
    );
    assign mul_result = returns_high(op_q) ? prod_fixed[2*W-1:W] : prod_fixed[W-1:0];

    assign div_raw  = is_rem(op_q) ? div_next[2*W-1:W] : div_next[W-1:0];
    assign div_sign = is_rem(op_q) ? rem_neg_q : neg_q;
    muldiv_negate #(.Width(W)) u_fix_div (.neg_i(div_sign), .a_i(div_raw), .y_o(div_fixed));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rd_out_d  = rd_out_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        unique case (state_q)
            StIdle: begin
                if (valid_i && !flush_i) begin
                    op_d      = op_in;
                    rd_d      = rd_i;
                    cnt_d     = '0;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    if (special_zero || special_ovf) begin
                        state_d  = StDone;
                        result_d = special_res;
                        rd_out_d = rd_i;
                    end else if (is_div(op_in)) begin
                        state_d = StDiv;
                        acc_d   = {{W{1'b0}}, a_mag};
                        opnd_d  = b_mag;
                    end else begin
                        state_d = StMul;
                        acc_d   = {{W{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                    end
                end
            end
            StMul, StDiv: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d = (state_q == StMul) ? mul_next : div_next;
                    if (cnt_q == CntLast) begin
                        state_d  = StDone;
                        result_d = (state_q == StMul) ? mul_result : div_fixed;
                        rd_out_d = rd_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            op_q      <= OpMul;
            rd_q      <= '0;
            rd_out_q  <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rd_out_q  <= rd_out_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign ready_o  = (state_q == StIdle);
    assign busy_o   = (state_q != StIdle);
    assign valid_o  = (state_q == StDone);
    assign result_o = result_q;
    assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model feeding a scoreboard,
// plus literal expectations, latency/busy checks, flush, reset and handshake corner cases.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [2:0]    op_i = '0;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic [4:0]    rd_i = '0;
    logic          flush_i = 1'b0;
    logic          valid_o;
    logic [W-1:0]  result_o;
    logic [4:0]    rd_o;
    logic          busy_o;

    muldiv_unit #(.DATA_WIDTH(W), .REG_ADDR_WIDTH(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .rd_i    (rd_i),
        .flush_i (flush_i),
        .valid_o (valid_o),
        .result_o(result_o),
        .rd_o    (rd_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   rd;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   acc_cyc = 0;

    // Reference results straight from RISC-V arithmetic on 64-bit integers.
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          ub = longint'({32'h0, b});
        longint unsigned uu = {32'h0, a} * {32'h0, b};
        longint          p;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return uu[63:32];
            3'd4: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rd);
        exp_t e;
        e.res = model(op, a, b);
        e.rd  = rd;
        q.push_back(e);
        chk("ready_before_issue", ready_o, 1);
        valid_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        rd_i    = rd;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input int exp_lat, input logic [W-1:0] exp_res,
                             input logic [4:0] exp_rd, input bit poke);
        int busy_hi = 0;
        bit done    = 0;
        int lat     = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (busy_o) busy_hi++;
            if (valid_o) begin
                done = 1;
                lat  = cyc - acc_cyc + 1;
            end else begin
                if (poke) begin
                    valid_i = 1'b1;
                    op_i    = 3'd5;
                    a_i     = 32'd1;
                    b_i     = 32'd0;
                    rd_i    = 5'd31;
                end
                @(posedge clk);
                #1;
            end
        end
        valid_i = 1'b0;
        chk("done_seen", done, 1);
        chk("latency", lat, exp_lat);
        chk("busy_cycles", busy_hi, exp_lat);
        chk("result_literal", result_o, exp_res);
        chk("rd_literal", rd_o, exp_rd);
        @(posedge clk);
        #1;
        chk("ready_after", ready_o, 1);
        chk("busy_after", busy_o, 0);
        chk("result_held", result_o, exp_res);
    endtask

    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd, input int lat, input logic [W-1:0] exp_res);
        start(op, a, b, rd);
        wait_done(lat, exp_res, rd, 1'b0);
    endtask

    initial begin
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (valid_o) begin
                        if (q.size() == 0) begin
                            chk("unexpected_valid", valid_o, 0);
                        end else begin
                            e = q.pop_front();
                            chk("sb_result", result_o, e.res);
                            chk("sb_rd", rd_o, e.rd);
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result_o, 0);
        chk("rst_rd", rd_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_busy", busy_o, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Multiply family
        run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 33, 32'hFFFF_FFEB);
        run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 33, 32'h4000_0000);
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 33, 32'hFFFF_FFFE);
        run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 33, 32'hFFFF_FFFF);
        run(3'd1, 32'hFFFF_FFFB, 32'd3, 5'd9, 33, 32'hFFFF_FFFF);

        // Divide family
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 33, 32'hFFFF_FFFD);
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 33, 32'hFFFF_FFFF);
        run(3'd5, 32'd100, 32'd7, 5'd12, 33, 32'd14);
        run(3'd7, 32'd100, 32'd7, 5'd13, 33, 32'd2);
        run(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd14, 33, 32'hFFFF_FFFD);
        run(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd15, 33, 32'd1);

        // Short-circuit cases
        run(3'd5, 32'd123, 32'd0, 5'd16, 1, 32'hFFFF_FFFF);
        run(3'd6, 32'd123, 32'd0, 5'd17, 1, 32'd123);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 1, 32'h8000_0000);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 1, 32'd0);

        // Flush after 10 divide iterations: no result, outputs untouched
        start(3'd4, 32'd1000, 32'd3, 5'd20);
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        void'(q.pop_back());
        chk("flush_ready", ready_o, 1);
        chk("flush_busy", busy_o, 0);
        chk("flush_result_kept", result_o, 32'd0);
        chk("flush_rd_kept", rd_o, 5'd19);
        repeat (40) @(posedge clk);
        #1;
        run(3'd0, 32'd3, 32'd4, 5'd21, 33, 32'd12);

        // Reset mid-multiply drops the operation
        start(3'd0, 32'd5, 32'd6, 5'd22);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        chk("midrst_result", result_o, 0);
        chk("midrst_rd", rd_o, 0);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_ready", ready_o, 1);
        chk("midrst_busy", busy_o, 0);
        repeat (40) @(posedge clk);
        #1;

        // Requests while busy are ignored
        start(3'd3, 32'd9, 32'd11, 5'd23);
        wait_done(33, 32'd0, 5'd23, 1'b1);

        // valid_i with flush_i in idle is not accepted
        valid_i = 1'b1;
        flush_i = 1'b1;
        op_i    = 3'd5;
        a_i     = 32'd1;
        b_i     = 32'd0;
        rd_i    = 5'd30;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("flushreq_ready", ready_o, 1);
            chk("flushreq_busy", busy_o, 0);
        end
        valid_i = 1'b0;
        flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("flushreq_rd_kept", rd_o, 5'd23);
        chk("sb_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative M-extension execution unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with DATA_WIDTH generalised operands. Sits beside the execute-stage ALU and accepts one operation at a time over a valid/ready handshake. It holds the pipeline via busy_o while iterating, and returns the result with its destination register for writeback. Divide-by-zero and signed overflow follow the RISC-V spec.

Parameters:
DATA_WIDTH, 32, operand/result width (even, >= 8)
REG_ADDR_WIDTH, 5, destination register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset (rst=0 resets)
valid_i  in  1  operation request
ready_o  out  1  unit can accept (high only in IDLE)
op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a_i  in  DATA_WIDTH  rs1 operand
b_i  in  DATA_WIDTH  rs2 operand
rd_i  in  REG_ADDR_WIDTH  destination register
flush_i  in  1  abort in-flight operation (branch mispredict)
valid_o  out  1  one-cycle result strobe
result_o  out  DATA_WIDTH  result, held until next result
rd_o  out  REG_ADDR_WIDTH  destination of result_o
busy_o  out  1  high when state != IDLE (pipeline stall)

Behaviour:
- Reset (rst=0 at posedge): state IDLE, valid_o=0, result_o=0, rd_o=0, counter=0, busy_o=0, ready_o=1. Reset mid-operation drops it silently.
- States: IDLE, MUL, DIV, DONE.
- IDLE: accept when valid_i & ready_o & !flush_i. Latch op, rd, |a|, |b| (magnitude taken only for signed operand positions), result sign, counter=0.
  - op 4-7 with b_i==0 -> DONE directly. DIV/DIVU result all-ones; REM/REMU result a_i.
  - op 4/6 with a_i==most-negative and b_i==all-ones -> DONE directly. DIV result a_i, REM result 0.
  - other op 0-3 -> MUL; op 4-7 -> DIV.
- MUL: radix-2 shift-add on the 2*DATA_WIDTH-bit accumulator, one multiplier bit per cycle, exactly DATA_WIDTH cycles. Then DONE.
  - Signed sign fix: two's-complement negate of the 2W product when the latched sign is set.
  - Operand signedness: MULH signed x signed; MULHSU signed a x unsigned b; MULHU unsigned x unsigned.
  - MUL returns the low W bits; the others return the high W bits.
- DIV: restoring shift-subtract, one quotient bit per cycle, exactly DATA_WIDTH cycles. Then DONE.
  - Quotient negated if the operand signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
- DONE: valid_o=1 for exactly this cycle, result_o/rd_o valid. Next state IDLE. ready_o=0 in DONE, so there is no back-to-back accept.
- Latency, accept edge to valid_o cycle:
  - Normal: DATA_WIDTH+1 cycles (33 at W=32).
  - Special case: 1 cycle.
  - Next accept: the cycle after DONE.
- flush_i=1 in MUL/DIV/DONE -> IDLE next cycle, no valid_o, result_o/rd_o unchanged.
- flush_i and valid_i both high in IDLE -> not accepted.
- result_o/rd_o only update on entry to DONE, via a registered update.
- Counter is $clog2(DATA_WIDTH)+1 bits and does not wrap; the terminal count is DATA_WIDTH-1.

Decomposition:
- Shared package muldiv_pkg:
  - op enum muldiv_op_e (values 0-7 above)
  - state enum muldiv_state_e
  - helper functions is_div(op), is_signed_a(op), is_signed_b(op), returns_high(op)
- One sub-module, muldiv_negate: parametrised-width conditional two's-complement (used for operand magnitude and result fix). Everything else stays in muldiv_unit.

Test Plan:
1. W=32, MUL a=7 b=-3 (0xFFFFFFFD), rd=5 -> valid_o 33 cycles after accept, result_o=0xFFFFFFEB, rd_o=5, busy_o high for 33 cycles.
2. MULH a=0x80000000 b=0x80000000 -> result_o=0x40000000; MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=-1 b=0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV a=-7 b=2 -> 0xFFFFFFFD (-3); REM a=-7 b=2 -> 0xFFFFFFFF (-1); DIVU a=100 b=7 -> 14; REMU -> 2.
4. DIVU a=123 b=0 -> valid_o 1 cycle after accept, 0xFFFFFFFF; REM a=123 b=0 -> 123; DIV a=0x80000000 b=-1 -> 0x80000000; REM same operands -> 0.
5. Start DIV, assert flush_i at iteration 10 -> IDLE next cycle, no valid_o, ready_o=1. Then MUL 3x4 -> 12 with normal latency.
6. rst=0 mid-MUL for one edge -> all outputs zero, ready_o=1. valid_i during busy -> ignored. valid_i with flush_i in IDLE -> not accepted.
